// File: rtl/chacha_loader_pkg.sv
// Shared definitions for the ChaCha input loader: field sizes, byte index
// width, loader FSM states and the ChaCha "expand 32-byte k" constant words
// used by the core when it builds its initial state.
package chacha_loader_pkg;

  localparam int KEY_BYTES   = 32;
  localparam int NONCE_BYTES = 12;
  localparam int CTR_BYTES   = 4;
  localparam int IDX_W       = 5;   // byte index, max 31

  localparam logic [31:0] CHACHA_C0 = 32'h6170_7865;
  localparam logic [31:0] CHACHA_C1 = 32'h3320_646e;
  localparam logic [31:0] CHACHA_C2 = 32'h7962_2d32;
  localparam logic [31:0] CHACHA_C3 = 32'h6b20_6574;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LD_KEY = 2'd1,
    ST_LD_NNC = 2'd2,
    ST_LD_CTR = 2'd3
  } ld_state_t;

  // Index of the final byte of an n-byte field.
  function automatic logic [IDX_W-1:0] last_idx(input int n);
    return IDX_W'(n - 1);
  endfunction

endpackage

// File: rtl/chacha_byte_field.sv
// N-byte little-endian register with a byte-indexed write port, a whole-word
// write port (lower priority) and a valid flag.
//  clk, rst_n        clock, synchronous active-low reset
//  byte_we/byte_idx  write byte_din into byte byte_idx
//  word_we/word_din  overwrite the whole field (used for counter increment)
//  start / done      clear / set the valid flag (start wins)
//  data, vld         field contents and valid flag
module chacha_byte_field
  import chacha_loader_pkg::*;
#(
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             byte_we,
  input  logic [IDX_W-1:0] byte_idx,
  input  logic [7:0]       byte_din,
  input  logic             word_we,
  input  logic [8*N-1:0]   word_din,
  input  logic             start,
  input  logic             done,
  output logic [8*N-1:0]   data,
  output logic             vld
);

  for (genvar b = 0; b < N; b++) begin : g_byte
    always_ff @(posedge clk) begin
      if (!rst_n)
        data[8*b +: 8] <= '0;
      else if (byte_we && byte_idx == IDX_W'(b))
        data[8*b +: 8] <= byte_din;
      else if (word_we)
        data[8*b +: 8] <= word_din[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)     vld <= 1'b0;
    else if (start) vld <= 1'b0;
    else if (done)  vld <= 1'b1;
  end

endmodule

// File: rtl/chacha_loader.sv
// Byte-serial loader for ChaCha key / nonce / block counter.
//  clk, rst_n                 clock, synchronous active-low reset
//  wr_key/wr_nnc/wr_ctr       load strobes; data_in on the strobe cycle is byte 0
//  data_in                    byte bus, one byte per cycle during a load
//  ctr_inc                    advance block counter (mod 2^CW)
//  key, nonce, counter        little-endian fields
//  key_vld/nnc_vld/ctr_vld    per-field complete flags
//  cfg_valid                  all fields valid and no load running
//  busy                       load in progress
//  ctr_wrap                   sticky counter wrap, cleared by counter load
module chacha_loader
  import chacha_loader_pkg::*;
#(
  parameter int KEY_BYTES_P   = KEY_BYTES,
  parameter int NONCE_BYTES_P = NONCE_BYTES,
  parameter int CTR_BYTES_P   = CTR_BYTES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_key,
  input  logic                       wr_nnc,
  input  logic                       wr_ctr,
  input  logic [7:0]                 data_in,
  input  logic                       ctr_inc,
  output logic [8*KEY_BYTES_P-1:0]   key,
  output logic [8*NONCE_BYTES_P-1:0] nonce,
  output logic [8*CTR_BYTES_P-1:0]   counter,
  output logic                       key_vld,
  output logic                       nnc_vld,
  output logic                       ctr_vld,
  output logic                       cfg_valid,
  output logic                       busy,
  output logic                       ctr_wrap
);

  localparam int CW = 8 * CTR_BYTES_P;

  ld_state_t        state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] wr_idx;
  logic acc_key, acc_nnc, acc_ctr;
  logic key_last, nnc_last, ctr_last;
  logic ctr_bump;

  // Strobes only count in IDLE; fixed priority key > nonce > counter.
  assign acc_key = (state == ST_IDLE) && wr_key;
  assign acc_nnc = (state == ST_IDLE) && !wr_key && wr_nnc;
  assign acc_ctr = (state == ST_IDLE) && !wr_key && !wr_nnc && wr_ctr;

  assign key_last = (state == ST_LD_KEY) && (idx == last_idx(KEY_BYTES_P));
  assign nnc_last = (state == ST_LD_NNC) && (idx == last_idx(NONCE_BYTES_P));
  assign ctr_last = (state == ST_LD_CTR) && (idx == last_idx(CTR_BYTES_P));

  // Byte 0 lands on the strobe edge, so IDLE always writes index 0.
  assign wr_idx = (state == ST_IDLE) ? '0 : idx;

  // A counter load in progress (or starting) owns the counter register.
  assign ctr_bump = ctr_inc && (state != ST_LD_CTR) && !acc_ctr;

  chacha_byte_field #(.N(KEY_BYTES_P)) u_key (
    .clk, .rst_n,
    .byte_we (acc_key || state == ST_LD_KEY), .byte_idx(wr_idx), .byte_din(data_in),
    .word_we (1'b0), .word_din('0),
    .start   (acc_key), .done(key_last),
    .data    (key), .vld(key_vld)
  );

  chacha_byte_field #(.N(NONCE_BYTES_P)) u_nnc (
    .clk, .rst_n,
    .byte_we (acc_nnc || state == ST_LD_NNC), .byte_idx(wr_idx), .byte_din(data_in),
    .word_we (1'b0), .word_din('0),
    .start   (acc_nnc), .done(nnc_last),
    .data    (nonce), .vld(nnc_vld)
  );

  chacha_byte_field #(.N(CTR_BYTES_P)) u_ctr (
    .clk, .rst_n,
    .byte_we (acc_ctr || state == ST_LD_CTR), .byte_idx(wr_idx), .byte_din(data_in),
    .word_we (ctr_bump), .word_din(counter + CW'(1)),
    .start   (acc_ctr), .done(ctr_last),
    .data    (counter), .vld(ctr_vld)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      idx      <= '0;
      busy     <= 1'b0;
      ctr_wrap <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (acc_key || acc_nnc || acc_ctr) begin
            idx  <= IDX_W'(1);
            busy <= 1'b1;
            if (acc_key)      state <= ST_LD_KEY;
            else if (acc_nnc) state <= ST_LD_NNC;
            else              state <= ST_LD_CTR;
          end
        end
        ST_LD_KEY, ST_LD_NNC, ST_LD_CTR: begin
          if (key_last || nnc_last || ctr_last) begin
            state <= ST_IDLE;
            idx   <= '0;
            busy  <= 1'b0;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (acc_ctr)
        ctr_wrap <= 1'b0;
      else if (ctr_bump && counter == '1)
        ctr_wrap <= 1'b1;
    end
  end

  // Function of registered flags only.
  assign cfg_valid = key_vld && nnc_vld && ctr_vld && !busy;

endmodule

// File: tb/tb_chacha_loader.sv
module tb_chacha_loader;

  logic         clk = 1'b0;
  logic         rst_n, wr_key, wr_nnc, wr_ctr, ctr_inc;
  logic [7:0]   data_in;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  counter;
  logic         key_vld, nnc_vld, ctr_vld, cfg_valid, busy, ctr_wrap;

  always #5 clk = ~clk;

  chacha_loader dut (
    .clk(clk), .rst_n(rst_n), .wr_key(wr_key), .wr_nnc(wr_nnc), .wr_ctr(wr_ctr),
    .data_in(data_in), .ctr_inc(ctr_inc), .key(key), .nonce(nonce), .counter(counter),
    .key_vld(key_vld), .nnc_vld(nnc_vld), .ctr_vld(ctr_vld), .cfg_valid(cfg_valid),
    .busy(busy), .ctr_wrap(ctr_wrap)
  );

  typedef struct {
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  ctr;
    logic kv, nv, cv, busy, cfg, wrap;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: which field is loading (0 none, 1 key, 2 nonce, 3 ctr)
  // and how many bytes of it have arrived.
  logic [255:0] m_key;
  logic [95:0]  m_nnc;
  logic [31:0]  m_ctr;
  logic m_kv, m_nv, m_cv, m_wrap;
  int   m_act, m_pos;

  function automatic int flen(input int a);
    return (a == 1) ? 32 : (a == 2) ? 12 : 4;
  endfunction

  task automatic chk(input string n, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @%0t got %h want %h", n, $time, got, want);
    end
  endtask

  task automatic model(input logic r, wk, wn, wc, input logic [7:0] d, input logic inc);
    logic bump;
    if (!r) begin
      m_key = '0; m_nnc = '0; m_ctr = '0;
      m_kv = 0; m_nv = 0; m_cv = 0; m_wrap = 0; m_act = 0; m_pos = 0;
      return;
    end
    bump = inc && m_act != 3 && !(m_act == 0 && !wk && !wn && wc);
    if (m_act == 0) begin
      m_pos = 0;
      if (wk)      begin m_act = 1; m_kv = 0; end
      else if (wn) begin m_act = 2; m_nv = 0; end
      else if (wc) begin m_act = 3; m_cv = 0; m_wrap = 0; end
    end
    if (bump) begin
      if (m_ctr == 32'hFFFF_FFFF) m_wrap = 1;
      m_ctr = m_ctr + 1;
    end
    if (m_act != 0) begin
      case (m_act)
        1: m_key[8*m_pos +: 8] = d;
        2: m_nnc[8*m_pos +: 8] = d;
        default: m_ctr[8*m_pos +: 8] = d;
      endcase
      m_pos++;
      if (m_pos == flen(m_act)) begin
        case (m_act)
          1: m_kv = 1;
          2: m_nv = 1;
          default: m_cv = 1;
        endcase
        m_act = 0;
      end
    end
  endtask

  task automatic step(input logic r, wk, wn, wc, input logic [7:0] d, input logic inc);
    exp_t e;
    rst_n = r; wr_key = wk; wr_nnc = wn; wr_ctr = wc; data_in = d; ctr_inc = inc;
    model(r, wk, wn, wc, d, inc);
    e.key = m_key; e.nonce = m_nnc; e.ctr = m_ctr;
    e.kv = m_kv; e.nv = m_nv; e.cv = m_cv; e.busy = (m_act != 0);
    e.cfg = m_kv && m_nv && m_cv && (m_act == 0); e.wrap = m_wrap;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 8'($urandom), 0);
  endtask

  task automatic load(input int which, input logic [255:0] val, input int n);
    for (int i = 0; i < n; i++)
      step(1, which == 1 && i == 0, which == 2 && i == 0, which == 3 && i == 0, val[8*i +: 8], 0);
  endtask

  // Monitor: one expectation per clock edge, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("key", key, e.key);
      chk("nonce", nonce, e.nonce);
      chk("counter", counter, e.ctr);
      chk("flags", {key_vld, nnc_vld, ctr_vld, busy, cfg_valid, ctr_wrap},
          {e.kv, e.nv, e.cv, e.busy, e.cfg, e.wrap});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [255:0] v, kexp;
    logic [255:0] nval;
    rst_n = 0; wr_key = 0; wr_nnc = 0; wr_ctr = 0; data_in = 0; ctr_inc = 0;
    m_act = 0;
    repeat (3) step(0, 0, 0, 0, 0, 0);

    // Key 00..1F
    for (int i = 0; i < 32; i++) begin v[8*i +: 8] = 8'(i); kexp[8*i +: 8] = 8'(i); end
    load(1, v, 32);
    chk("key_const", key, kexp);
    chk("key_vld_done", key_vld, 1);
    idle(2);

    // Nonce and counter -> full config
    nval = 256'h0000_0009_0000_004A_0000_0000;
    load(2, nval, 12);
    load(3, 256'h1, 4);
    chk("counter_one", counter, 32'd1);
    chk("cfg_valid", cfg_valid, 1);
    idle(2);

    // Collision: key wins over counter; nonce/counter strobes mid-key ignored
    v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    step(1, 1, 0, 1, v[7:0], 0);
    for (int i = 1; i < 32; i++) step(1, 0, i == 5, i == 9, v[8*i +: 8], i == 7);
    chk("ctr_vld_kept", ctr_vld, 1);
    idle(1);

    // Wrap, then counter reload clears it
    load(3, 256'hFFFF_FFFF, 4);
    step(1, 0, 0, 0, 0, 1);
    chk("wrap_ctr", counter, 32'd0);
    chk("wrap_flag", ctr_wrap, 1);
    idle(1);
    load(3, 256'h1234_5678, 4);

    // Race: increment with counter strobe is dropped
    step(1, 0, 0, 1, 8'h05, 1);
    for (int i = 1; i < 4; i++) step(1, 0, 0, 0, 8'h00, 1);
    chk("race_ctr", counter, 32'd5);
    step(1, 0, 0, 0, 0, 1);

    // Reset at byte 10 of key load, then clean reload
    load(1, v, 10);
    step(0, 0, 0, 0, 0, 0);
    chk("rst_key", key, 0);
    chk("rst_busy", busy, 0);
    load(1, kexp, 32);
    idle(1);

    // Random traffic
    for (int c = 0; c < 3000; c++)
      step($urandom_range(0, 499) != 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
           8'($urandom), $urandom_range(0, 3) == 0);
    // Force a wrap in the random state too
    load(3, 256'hFFFF_FFFE, 4);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    idle(3);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain pending %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
